// File: rtl/led_seq_pkg.sv
// -----------------------------------------------------------------------------
// led_seq_pkg
// Shared types and helpers for the LED sequencer:
//   mode_e      - display mode (COUNT, GRAY, SHIFT, OFF), 2 bits
//   state_e     - lock FSM state (RUN, LOCK)
//   led_pattern - maps (mode, step) to an LED pattern, LSB-aligned in a
//                 LED_MAX_W-bit word; callers keep the low BITS bits.
// -----------------------------------------------------------------------------
package led_seq_pkg;

   localparam int unsigned LED_MAX_W = 32;
   localparam int unsigned HOLD_W    = 8;

   typedef enum logic [1:0] {
      COUNT = 2'd0,
      GRAY  = 2'd1,
      SHIFT = 2'd2,
      OFF   = 2'd3
   } mode_e;

   typedef enum logic {
      RUN  = 1'b0,
      LOCK = 1'b1
   } state_e;

   // bits is a power of two, so "step mod bits" is a simple mask.
   function automatic logic [LED_MAX_W-1:0] led_pattern(
      input mode_e                m,
      input logic [LED_MAX_W-1:0] step,
      input logic [LED_MAX_W-1:0] bits
   );
      logic [LED_MAX_W-1:0] pat;
      case (m)
         COUNT:   pat = step;
         GRAY:    pat = step ^ (step >> 1);
         SHIFT:   pat = LED_MAX_W'(1) << (step & (bits - LED_MAX_W'(1)));
         default: pat = '0;
      endcase
      return pat;
   endfunction

endpackage

// File: rtl/led_seq_if.sv
// -----------------------------------------------------------------------------
// led_seq_if
// Mode-change request channel from two requesters to the sequencer.
//   req_valid[i]         - requester i wants a mode change
//   req_mode[2i+1:2i]    - mode requested by requester i
//   req_ready[i]         - grant to requester i; transfer when valid & ready
// master: requester side, slave: sequencer side.
// -----------------------------------------------------------------------------
interface led_seq_if;

   logic [1:0] req_valid;
   logic [3:0] req_mode;
   logic [1:0] req_ready;

   modport master (
      output req_valid,
      output req_mode,
      input  req_ready
   );

   modport slave (
      input  req_valid,
      input  req_mode,
      output req_ready
   );

endinterface

// File: rtl/led_seq_rr_arb.sv
// -----------------------------------------------------------------------------
// led_seq_rr_arb
// Two-way round-robin arbiter with a registered priority pointer.
//   clk, rst_n - clock, asynchronous active-low reset
//   valid_i    - per-requester request
//   enable_i   - grants allowed this cycle
//   grant_o    - one-hot (or zero) combinational grant
// With both requesters valid, the one equal to the pointer wins; after a
// grant to requester i the pointer moves to the other requester.
// -----------------------------------------------------------------------------
module led_seq_rr_arb (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] valid_i,
   input  logic       enable_i,
   output logic [1:0] grant_o
);

   logic ptr_q;
   logic ptr_d;

   always_comb begin
      // NOTE: every output of a combinational block gets a default first,
      // otherwise an unassigned path infers a latch.
      grant_o = 2'b00;
      ptr_d   = ptr_q;
      if (enable_i) begin
         if (valid_i[0] && (!valid_i[1] || !ptr_q)) begin
            grant_o = 2'b01;
         end else if (valid_i[1]) begin
            grant_o = 2'b10;
         end
      end
      if (grant_o[0]) begin
         ptr_d = 1'b1;
      end else if (grant_o[1]) begin
         ptr_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state is updated with non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (!rst_n) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/led_seq_ctrl.sv
// -----------------------------------------------------------------------------
// led_seq_ctrl
// LED pattern sequencer. A prescaler produces a tick every 2^LOG2DELAY
// cycles, a step counter advances on each tick, and the LED register shows
// f(mode, step) one cycle later. Two requesters may change the mode through
// a round-robin arbiter; an accepted mode is locked for HOLD_TICKS ticks.
//   clk, rst_n - clock, asynchronous active-low reset
//   req        - request channel (slave side): valid, mode, ready
//   led        - registered LED pattern, led[BITS-1] is the MSB
//   mode       - active mode
//   busy       - mode is locked, no requests are accepted
// -----------------------------------------------------------------------------
module led_seq_ctrl
   import led_seq_pkg::*;
#(
   parameter int BITS       = 4,
   parameter int LOG2DELAY  = 23,
   parameter int HOLD_TICKS = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   led_seq_if.slave        req,
   output logic [BITS-1:0] led,
   output logic [1:0]      mode,
   output logic            busy
);

   logic [LOG2DELAY-1:0] presc_q;
   logic [BITS-1:0]      step_q;
   logic [HOLD_W-1:0]    hold_q;
   mode_e                mode_q;
   state_e               state_q;
   logic [BITS-1:0]      led_q;
   logic [BITS-1:0]      led_d;
   logic [LED_MAX_W-1:0] pattern;

   logic       tick;
   logic       arb_en;
   logic [1:0] grant;
   logic       accept;
   mode_e      acc_mode;

   assign tick = &presc_q;

   // Gating with rst_n keeps req_ready low for the whole reset, not just
   // from the first clock edge.
   assign arb_en = rst_n && (state_q == RUN);

   led_seq_rr_arb u_arb (
      .clk      (clk),
      .rst_n    (rst_n),
      .valid_i  (req.req_valid),
      .enable_i (arb_en),
      .grant_o  (grant)
   );

   assign req.req_ready = grant;
   assign accept        = |grant;
   assign acc_mode      = mode_e'(grant[1] ? req.req_mode[3:2] : req.req_mode[1:0]);

   always_comb begin
      pattern = led_pattern(mode_q, LED_MAX_W'(step_q), LED_MAX_W'(BITS));
      led_d   = pattern[BITS-1:0];
   end

   // Accept has priority over the tick: a coinciding tick is discarded so
   // the new mode always starts from step 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q <= '0;
         step_q  <= '0;
         hold_q  <= '0;
         mode_q  <= COUNT;
         state_q <= RUN;
         led_q   <= '0;
      end else begin
         led_q <= led_d;
         if (accept) begin
            presc_q <= '0;
            step_q  <= '0;
            hold_q  <= HOLD_W'(HOLD_TICKS);
            mode_q  <= acc_mode;
            state_q <= LOCK;
         end else begin
            presc_q <= presc_q + 1'b1;
            if (tick) begin
               step_q <= step_q + 1'b1;
               if (state_q == LOCK) begin
                  hold_q <= hold_q - 1'b1;
                  if (hold_q == HOLD_W'(1)) begin
                     state_q <= RUN;
                  end
               end
            end
         end
      end
   end

   assign led  = led_q;
   assign mode = mode_q;
   assign busy = (state_q == LOCK);

endmodule

// File: tb/tb_led_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_led_seq_ctrl
// Directed bench for led_seq_ctrl with BITS=4, LOG2DELAY=2, HOLD_TICKS=2.
// Outputs are sampled 1 time unit after the rising edge; a separate process
// checks the handshake rules on every falling edge.
// -----------------------------------------------------------------------------
module tb_led_seq_ctrl;

   localparam int BITS       = 4;
   localparam int LOG2DELAY  = 2;
   localparam int HOLD_TICKS = 2;

   logic            clk;
   logic            rst_n;
   logic [BITS-1:0] led;
   logic [1:0]      mode;
   logic            busy;

   led_seq_if bus ();

   led_seq_ctrl #(
      .BITS       (BITS),
      .LOG2DELAY  (LOG2DELAY),
      .HOLD_TICKS (HOLD_TICKS)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (bus),
      .led   (led),
      .mode  (mode),
      .busy  (busy)
   );

   int checks   = 0;
   int failures = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Handshake rules, every cycle.
   always @(negedge clk) begin
      check("rdy_not_both", 32'(bus.req_ready == 2'b11), 32'd0);
      check("rdy_without_valid", 32'(bus.req_ready & ~bus.req_valid), 32'd0);
      check("rdy_in_lock", 32'(busy ? bus.req_ready : 2'b00), 32'd0);
   end

   initial begin
      rst_n         = 1'b1;
      bus.req_valid = 2'b00;
      bus.req_mode  = 4'b0000;
      #1 rst_n = 1'b0;
      #2;
      check("reset_led", 32'(led), 32'd0);
      check("reset_mode", 32'(mode), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_ready", 32'(bus.req_ready), 32'd0);

      // Free-running COUNT: tick every 4 cycles, led lags step by one cycle.
      next_cycle();
      next_cycle();
      rst_n = 1'b1;
      for (int k = 1; k <= 68; k++) begin
         next_cycle();
         check("count_led", 32'(led), 32'(((k - 1) >> 2) & 15));
         check("count_busy", 32'(busy), 32'd0);
      end
      check("count_mode", 32'(mode), 32'd0);

      // Reset again, both requesters valid: req0 GRAY, req1 SHIFT.
      rst_n         = 1'b0;
      bus.req_valid = 2'b11;
      bus.req_mode  = 4'b1001;
      #1;
      check("rst_ready_both_valid", 32'(bus.req_ready), 32'd0);
      check("rst_led", 32'(led), 32'd0);
      next_cycle();
      rst_n = 1'b1;
      #1;
      check("first_grant", 32'(bus.req_ready), 32'h1);
      for (int n = 1; n <= 9; n++) begin
         next_cycle();
         check("gray_busy", 32'(busy), (n <= 8) ? 32'd1 : 32'd0);
         check("gray_ready", 32'(bus.req_ready), (n <= 8) ? 32'd0 : 32'h2);
         check("gray_mode", 32'(mode), 32'd1);
         check("gray_led", 32'(led), (n >= 6) ? 32'd1 : 32'd0);
      end

      // SHIFT accepted from requester 1.
      next_cycle();
      bus.req_valid = 2'b00;
      check("shift_mode", 32'(mode), 32'd2);
      check("shift_busy", 32'(busy), 32'd1);
      for (int n = 11; n <= 27; n++) begin
         next_cycle();
         check("shift_led", 32'(led), 32'd1 << (((n - 11) >> 2) & 3));
         check("shift_busy_run", 32'(busy), (n <= 17) ? 32'd1 : 32'd0);
      end

      // Accept coinciding with a tick: only requester 1 valid, pointer at 0.
      next_cycle();
      next_cycle();
      bus.req_valid = 2'b10;
      bus.req_mode  = 4'b0100;
      #1;
      check("lone_req1_grant", 32'(bus.req_ready), 32'h2);
      next_cycle();
      bus.req_valid = 2'b00;
      check("tick_acc_mode", 32'(mode), 32'd1);
      check("tick_acc_busy", 32'(busy), 32'd1);
      for (int n = 31; n <= 35; n++) begin
         next_cycle();
         check("tick_acc_led", 32'(led), (n == 35) ? 32'd1 : 32'd0);
      end

      // Reset in the middle of LOCK with requests held.
      bus.req_valid = 2'b11;
      bus.req_mode  = 4'b1110;
      #2 rst_n = 1'b0;
      #1;
      check("midlock_led", 32'(led), 32'd0);
      check("midlock_mode", 32'(mode), 32'd0);
      check("midlock_busy", 32'(busy), 32'd0);
      check("midlock_ready", 32'(bus.req_ready), 32'd0);
      next_cycle();
      check("held_rst_ready", 32'(bus.req_ready), 32'd0);
      rst_n = 1'b1;
      #1;
      check("post_rst_grant", 32'(bus.req_ready), 32'h1);
      next_cycle();
      bus.req_valid = 2'b00;
      check("post_rst_mode", 32'(mode), 32'd2);
      check("post_rst_busy", 32'(busy), 32'd1);
      next_cycle();
      check("post_rst_led", 32'(led), 32'd1);

      repeat (4) next_cycle();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/led_seq_ctrl.md
LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 SHALL have parameter BITS, default 4, LED count; power of two, at least 2.
REQ-002 SHALL have parameter LOG2DELAY, default 23, prescaler width; one tick every 2^LOG2DELAY cycles.
REQ-003 SHALL have parameter HOLD_TICKS, default 2, range 1..255, ticks a newly accepted mode is locked.
REQ-004 SHALL have port clk  in  1  sole clock; all state rises on posedge clk.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port req_valid  in  2  per-requester mode-change request; bit i = requester i.
REQ-007 SHALL have port req_mode  in  4  requested mode, [2i+1:2i] for requester i; 0 COUNT, 1 GRAY, 2 SHIFT, 3 OFF.
REQ-008 SHALL have port req_ready  out  2  per-requester grant; transfer when valid and ready are both high in one cycle.
REQ-009 SHALL have port led  out  BITS  registered LED pattern; led[BITS-1] is the MSB and maps to led0 at top level.
REQ-010 SHALL have port mode  out  2  currently active mode.
REQ-011 SHALL have port busy  out  1  high while the mode is locked (state LOCK).

Function
REQ-012 Prescaler SHALL be LOG2DELAY bits, +1 every cycle, wrap to 0; internal tick high in the cycle the prescaler is all-ones.
REQ-013 Step counter SHALL be BITS bits, +1 on each tick, wrapping from 2^BITS-1 to 0.
REQ-014 led SHALL register f(mode, step) each cycle, one cycle of latency after a step or mode update.
REQ-015 f SHALL be: COUNT gives step; GRAY gives step^(step>>1); SHIFT gives 1<<(step mod BITS); OFF gives all zeros.
REQ-016 FSM SHALL have two states, RUN and LOCK; busy = (state==LOCK).
REQ-017 In LOCK, req_ready SHALL be 2'b00 and requests SHALL stay pending, never dropped or altered.
REQ-018 In RUN, req_ready SHALL be combinational from req_valid and the round-robin pointer.
REQ-019 In RUN, req_ready SHALL be one-hot or zero, and SHALL never be asserted to a requester with valid low.
REQ-020 Arbiter: only one valid requester SHALL win; with both valid, the requester equal to the pointer SHALL win.
REQ-021 After a grant to requester i, the pointer SHALL be set to 1-i.
REQ-022 On accept, next cycle: mode = accepted req_mode, step = 0, prescaler = 0, hold counter = HOLD_TICKS, state = LOCK.
REQ-023 Accept coinciding with tick SHALL follow the accept, so step becomes 0 and not incremented.
REQ-024 In LOCK, the hold counter SHALL decrement on each tick; the tick that takes it from 1 to 0 SHALL return state to RUN next cycle.
REQ-025 Step SHALL keep advancing during LOCK per REQ-013.
REQ-026 Requesting the already-active mode SHALL be a normal accept, including the step/prescaler clear and LOCK.

Reset
REQ-027 While rst_n is low, the block SHALL immediately force: prescaler 0, step 0, hold 0, mode COUNT, state RUN, pointer 0, led 0, busy 0.
REQ-028 req_ready SHALL be 2'b00 while rst_n is low.
REQ-029 Reset asserted mid-LOCK SHALL abandon the lock; no request is accepted until after rst_n deasserts.
REQ-030 Deassertion SHALL be used synchronously; the first prescaler increment occurs on the first posedge clk after rst_n is high.

Structure
REQ-031 Package led_seq_pkg SHALL hold the mode enum (COUNT/GRAY/SHIFT/OFF, 2 bits) and the state enum (RUN/LOCK).
REQ-032 led_seq_pkg SHALL also hold the function computing f.
REQ-033 Arbitration SHALL live in sub-module led_seq_rr_arb (2-way round-robin: valid, enable, pointer register, one-hot grant).
REQ-034 Prescaler, step counter, FSM and led register SHALL live in led_seq_ctrl.

Verification (BITS=4, LOG2DELAY=2, HOLD_TICKS=2)
REQ-035 No requests after reset -> tick every 4 cycles; led = 0,1,2,...,15,0 with one-cycle lag; busy stays 0.
REQ-036 Both valid in first cycle (req0 GRAY, req1 SHIFT) -> req_ready=01; mode=GRAY, busy=1 for 8 cycles; then req_ready=10 and SHIFT accepted.
REQ-037 SHIFT active -> led sequence 0001, 0010, 0100, 1000, 0001 on successive ticks.
REQ-038 Accept in the same cycle as a tick -> step=0 next cycle; next increment 4 cycles later.
REQ-039 rst_n low during LOCK with req0 held valid -> led=0, mode=COUNT, busy=0, req_ready=00 immediately.
REQ-040 After rst_n release in REQ-039 -> req0 accepted in the first RUN cycle.
REQ-041 Assertion on every cycle: req_ready never 2'b11, never set to a requester with valid low, never nonzero in LOCK.
